// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID-stage pipeline control and the hazard control unit.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [6:0]        id_opcode_i;
    logic              br_valid_i;
    logic              br_taken_i;
    logic              id_ex_memRead_i;
    logic [REG_AW-1:0] id_ex_regDest_i;
    logic [REG_AW-1:0] if_id_addrSrc1_i;
    logic [REG_AW-1:0] if_id_addrSrc2_i;
    logic              if_id_useSrc1_i;
    logic              if_id_useSrc2_i;
    logic              dmem_req_i;
    logic              dmem_ready_i;
    logic              stall_o;
    logic              flush_o;
    logic              freeze_o;
    logic              ctrlHazard_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_opcode_i, br_valid_i, br_taken_i, id_ex_memRead_i, id_ex_regDest_i,
               if_id_addrSrc1_i, if_id_addrSrc2_i, if_id_useSrc1_i, if_id_useSrc2_i,
               dmem_req_i, dmem_ready_i,
        input  stall_o, flush_o, freeze_o, ctrlHazard_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_opcode_i, br_valid_i, br_taken_i, id_ex_memRead_i, id_ex_regDest_i,
               if_id_addrSrc1_i, if_id_addrSrc2_i, if_id_useSrc1_i, if_id_useSrc2_i,
               dmem_req_i, dmem_ready_i,
        output stall_o, flush_o, freeze_o, ctrlHazard_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Sequential hazard control: load-use stall held for LOAD_LAT cycles, branch flush
// stretched over FLUSH_CYC cycles, memory-wait freeze and saturating event counters.
module hazard_ctrl_unit #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave bus
);
    localparam int MAX_LAT = (LOAD_LAT > FLUSH_CYC) ? LOAD_LAT : FLUSH_CYC;
    localparam int REM_W   = $clog2(MAX_LAT) + 1;
    localparam logic [REM_W-1:0] REM_ZERO     = {REM_W{1'b0}};
    localparam logic [REM_W-1:0] REM_ONE      = REM_W'(1);
    localparam logic [REM_W-1:0] LOAD_RELOAD  = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] FLUSH_RELOAD = REM_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [REM_W-1:0]  rem_r, rem_s;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;
    logic              stall_s, flush_s, flush_evt_s;
    logic              hz_s, br_s, freeze_s, ctrl_s;

    assign br_s     = bus.br_valid_i & bus.br_taken_i;
    assign freeze_s = bus.dmem_req_i & ~bus.dmem_ready_i;
    assign hz_s     = bus.id_ex_memRead_i
                    & (bus.id_ex_regDest_i != {REG_AW{1'b0}})
                    & ((bus.if_id_useSrc1_i & (bus.id_ex_regDest_i == bus.if_id_addrSrc1_i))
                     | (bus.if_id_useSrc2_i & (bus.id_ex_regDest_i == bus.if_id_addrSrc2_i)));

    // Control-transfer opcode decode (branch, jal, jalr)
    always_comb begin
        ctrl_s = 1'b0;
        case (bus.id_opcode_i)
            7'b1100011: ctrl_s = 1'b1;
            7'b1101111: ctrl_s = 1'b1;
            7'b1100111: ctrl_s = 1'b1;
            default:    ctrl_s = 1'b0;
        endcase
    end

    // Next-state, remaining-cycle count and stall/flush decisions
    always_comb begin
        state_s     = state_r;
        rem_s       = rem_r;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        flush_evt_s = 1'b0;
        if (rst_i) begin
            state_s = ST_RUN;
            rem_s   = REM_ZERO;
        end else if (freeze_s) begin
            state_s = state_r;
            rem_s   = rem_r;
        end else begin
            case (state_r)
                ST_RUN, ST_LU_STALL: begin
                    if (br_s) begin
                        // A taken branch abandons any pending load-use stall
                        flush_s     = 1'b1;
                        flush_evt_s = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_s = ST_FLUSH;
                            rem_s   = FLUSH_RELOAD;
                        end else begin
                            state_s = ST_RUN;
                            rem_s   = REM_ZERO;
                        end
                    end else if (state_r == ST_LU_STALL) begin
                        stall_s = 1'b1;
                        if (rem_r <= REM_ONE) begin
                            state_s = ST_RUN;
                            rem_s   = REM_ZERO;
                        end else begin
                            rem_s = rem_r - REM_ONE;
                        end
                    end else if (hz_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_s = ST_LU_STALL;
                            rem_s   = LOAD_RELOAD;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    flush_s = 1'b1;
                    if (br_s) begin
                        flush_evt_s = 1'b1;
                        rem_s       = FLUSH_RELOAD;
                    end else if (rem_r <= REM_ONE) begin
                        state_s = ST_RUN;
                        rem_s   = REM_ZERO;
                    end else begin
                        rem_s = rem_r - REM_ONE;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                    rem_s   = REM_ZERO;
                end
            endcase
        end
    end

    // State and remaining-cycle registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            rem_r   <= REM_ZERO;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
        end
    end

    // Saturating stall-cycle and flush-event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.stall_o      = stall_s;
    assign bus.flush_o      = flush_s;
    assign bus.freeze_o     = freeze_s & ~rst_i;
    assign bus.ctrlHazard_o = ctrl_s;
    assign bus.stall_cnt_o  = stall_cnt_r;
    assign bus.flush_cnt_o  = flush_cnt_r;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed plus random stimulus on two differently parameterised units, each
// checked every cycle against a remaining-cycles reference model.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, brv, brt, mr, u1, u2, dreq, drdy;
    logic [6:0] opc;
    logic [4:0] rd, s1, s2;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus_a ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus_b ();

    assign bus_a.id_opcode_i = opc;       assign bus_b.id_opcode_i = opc;
    assign bus_a.br_valid_i = brv;        assign bus_b.br_valid_i = brv;
    assign bus_a.br_taken_i = brt;        assign bus_b.br_taken_i = brt;
    assign bus_a.id_ex_memRead_i = mr;    assign bus_b.id_ex_memRead_i = mr;
    assign bus_a.id_ex_regDest_i = rd;    assign bus_b.id_ex_regDest_i = rd;
    assign bus_a.if_id_addrSrc1_i = s1;   assign bus_b.if_id_addrSrc1_i = s1;
    assign bus_a.if_id_addrSrc2_i = s2;   assign bus_b.if_id_addrSrc2_i = s2;
    assign bus_a.if_id_useSrc1_i = u1;    assign bus_b.if_id_useSrc1_i = u1;
    assign bus_a.if_id_useSrc2_i = u2;    assign bus_b.if_id_useSrc2_i = u2;
    assign bus_a.dmem_req_i = dreq;       assign bus_b.dmem_req_i = dreq;
    assign bus_a.dmem_ready_i = drdy;     assign bus_b.dmem_ready_i = drdy;

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_CYC(1), .CNT_W(16))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_CYC(2), .CNT_W(2))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    // Reference model: cycles of stall/flush still owed after the current one
    int ll   [2] = '{1, 3};
    int fc   [2] = '{1, 2};
    int cmax [2] = '{65535, 3};
    int sl [2], fl [2], scnt [2], fcnt [2];
    int nsl [2], nfl [2], nscnt [2], nfcnt [2];
    bit es [2], ef [2];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit br, frz, hz, ex;
        br  = brv & brt;
        frz = dreq & ~drdy;
        hz  = mr && (rd != 5'd0) && ((u1 && rd == s1) || (u2 && rd == s2));
        for (int k = 0; k < 2; k++) begin
            es[k] = 1'b0; ef[k] = 1'b0;
            nsl[k] = sl[k]; nfl[k] = fl[k]; nscnt[k] = scnt[k]; nfcnt[k] = fcnt[k];
            if (rst) begin
                nsl[k] = 0; nfl[k] = 0; nscnt[k] = 0; nfcnt[k] = 0;
            end else if (!frz) begin
                if (br) begin
                    ef[k] = 1'b1; nfl[k] = fc[k] - 1; nsl[k] = 0;
                    nfcnt[k] = (fcnt[k] < cmax[k]) ? fcnt[k] + 1 : cmax[k];
                end else if (fl[k] > 0) begin
                    ef[k] = 1'b1; nfl[k] = fl[k] - 1;
                end else if (sl[k] > 0) begin
                    es[k] = 1'b1; nsl[k] = sl[k] - 1;
                end else if (hz) begin
                    es[k] = 1'b1; nsl[k] = ll[k] - 1;
                end
                if (es[k]) nscnt[k] = (scnt[k] < cmax[k]) ? scnt[k] + 1 : cmax[k];
            end
        end
        ex = 1'b0;
        ex = (opc == 7'b1100011) || (opc == 7'b1101111) || (opc == 7'b1100111);
        chk("a_ctrl", {31'd0, bus_a.ctrlHazard_o}, {31'd0, ex});
        chk("b_ctrl", {31'd0, bus_b.ctrlHazard_o}, {31'd0, ex});
        chk("a_freeze", {31'd0, bus_a.freeze_o}, {31'd0, frz & ~rst});
        chk("b_freeze", {31'd0, bus_b.freeze_o}, {31'd0, frz & ~rst});
    endtask

    task automatic cycle();
        #1;
        model_eval();
        chk("a_stall", {31'd0, bus_a.stall_o}, {31'd0, es[0]});
        chk("a_flush", {31'd0, bus_a.flush_o}, {31'd0, ef[0]});
        chk("a_stall_cnt", {16'd0, bus_a.stall_cnt_o}, scnt[0]);
        chk("a_flush_cnt", {16'd0, bus_a.flush_cnt_o}, fcnt[0]);
        chk("b_stall", {31'd0, bus_b.stall_o}, {31'd0, es[1]});
        chk("b_flush", {31'd0, bus_b.flush_o}, {31'd0, ef[1]});
        chk("b_stall_cnt", {30'd0, bus_b.stall_cnt_o}, scnt[1]);
        chk("b_flush_cnt", {30'd0, bus_b.flush_cnt_o}, fcnt[1]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            sl[k] = nsl[k]; fl[k] = nfl[k]; scnt[k] = nscnt[k]; fcnt[k] = nfcnt[k];
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; opc = 7'b0110011; brv = 1'b0; brt = 1'b0; mr = 1'b0;
        rd = 5'd0; s1 = 5'd0; s2 = 5'd0; u1 = 1'b0; u2 = 1'b0; dreq = 1'b0; drdy = 1'b0;
    endtask

    task automatic hazard_x5();
        mr = 1'b1; rd = 5'd5; s1 = 5'd5; u1 = 1'b1; s2 = 5'd7; u2 = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            sl[k] = 0; fl[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
        cycle();
        idle(); cycle();
        // Load-use on rs1
        hazard_x5(); cycle();
        idle(); repeat (4) cycle();
        // x0 destination and unused operand never stall
        hazard_x5(); rd = 5'd0; s1 = 5'd0; cycle();
        hazard_x5(); u1 = 1'b0; cycle();
        hazard_x5(); rd = 5'd7; s1 = 5'd3; u2 = 1'b0; cycle();
        idle(); cycle();
        // Freeze for two cycles in the middle of a stall
        hazard_x5(); cycle();
        idle(); dreq = 1'b1; drdy = 1'b0; repeat (2) cycle();
        idle(); repeat (4) cycle();
        // Taken branch alongside a hazard, then a second taken branch
        hazard_x5(); brv = 1'b1; brt = 1'b1; cycle();
        idle(); brv = 1'b1; brt = 1'b1; cycle();
        idle(); repeat (3) cycle();
        // Reset during the second stall cycle
        hazard_x5(); cycle();
        idle(); rst = 1'b1; cycle();
        idle(); repeat (3) cycle();
        // Five spaced taken branches saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            idle(); brv = 1'b1; brt = 1'b1; cycle();
            idle(); repeat (2) cycle();
        end
        idle(); opc = 7'b1101111; cycle();
        idle(); opc = 7'b1100111; cycle();
        idle(); opc = 7'b1100011; brv = 1'b1; brt = 1'b0; cycle();
        // Random traffic with narrow register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            opc  = ($urandom_range(0, 1) == 0) ? 7'($urandom) : 7'b1100011;
            brv  = ($urandom_range(0, 3) == 0);
            brt  = $urandom_range(0, 1) == 1;
            mr   = $urandom_range(0, 1) == 1;
            rd   = 5'($urandom_range(0, 3));
            s1   = 5'($urandom_range(0, 3));
            s2   = 5'($urandom_range(0, 3));
            u1   = $urandom_range(0, 1) == 1;
            u2   = $urandom_range(0, 1) == 1;
            dreq = ($urandom_range(0, 3) == 0);
            drdy = $urandom_range(0, 1) == 1;
            cycle();
        end
        idle(); cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
